// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: PC sequencing, redirects, halt freeze.
// Optional fetch/bubble statistics counters are built only when FETCH_STATS_EN is defined.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   input  logic        pc_jump,
   input  logic        jump_sel,
   input  logic [31:0] jr_target,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic [5:0]  opcode,
   output logic [5:0]  func,
   output logic        halted,
   output logic [31:0] fetch_count,
   output logic [31:0] bubble_count
);

   // state  | meaning
   // S_BOOT | one cycle after reset; IF/ID loaded with a bubble, PC holds
   // S_RUN  | normal fetch with stall / redirect / halt handling
   // S_HALT | HALT_WORD reached ID; everything frozen until reset
   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

   state_t      state;
   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] redirect_pc;
   logic        redirect;
   logic        halt_seen;

   assign pc_plus4    = pc + 32'd4;
   assign jump_target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00};
   // A bubble in ID cannot have produced a redirect, so only a valid slot counts.
   assign redirect    = if_id_valid & (pc_jump | pc_src);
   assign halt_seen   = if_id_valid & (if_id_instr == HALT_WORD);
   assign redirect_pc = pc_jump ? (jump_sel ? jump_target : jr_target) : branch_target;

   assign opcode = if_id_instr[31:26];
   assign func   = if_id_instr[5:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_BOOT;
         pc             <= RESET_PC;
         if_id_instr    <= NOP_WORD;
         if_id_pc_plus4 <= 32'h0;
         if_id_valid    <= 1'b0;
         halted         <= 1'b0;
      end else begin
         case (state)
            S_BOOT: begin
               state       <= S_RUN;
               if_id_instr <= NOP_WORD;
               if_id_valid <= 1'b0;
            end
            S_RUN: begin
               if (!stall) begin
                  if (halt_seen) begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                  end else if (redirect) begin
                     pc          <= redirect_pc;
                     if_id_instr <= NOP_WORD;
                     if_id_valid <= 1'b0;
                  end else begin
                     pc             <= pc_plus4;
                     if_id_instr    <= imem_data;
                     if_id_pc_plus4 <= pc_plus4;
                     if_id_valid    <= 1'b1;
                  end
               end
            end
            default: begin
               state <= S_HALT;
            end
         endcase
      end
   end

`ifdef FETCH_STATS_EN
   logic load_valid;
   logic load_bubble;
   logic run_move;

   assign run_move    = (state == S_RUN) & ~stall & ~halt_seen;
   assign load_valid  = run_move & ~redirect;
   assign load_bubble = (state == S_BOOT) | (run_move & redirect);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count  <= 32'h0;
         bubble_count <= 32'h0;
      end else begin
         if (load_valid)  fetch_count  <= fetch_count + 32'd1;
         if (load_bubble) bubble_count <= bubble_count + 32'd1;
      end
   end
`else
   assign fetch_count  = 32'h0;
   assign bubble_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reference model plus IF/ID scoreboard queue.
module tb_fetch_stage;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] HALT_PC   = 32'h0000_0200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_data;
   logic        stall, pc_src, pc_jump, jump_sel;
   logic [31:0] branch_target, jr_target;
   logic [31:0] pc, if_id_instr, if_id_pc_plus4, fetch_count, bubble_count;
   logic        if_id_valid, halted;
   logic [5:0]  opcode, func;

   int checks = 0;
   int failures = 0;

   // reference model
   logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
   logic        m_valid, m_halted;
   int          m_state;   // 0 boot, 1 run, 2 halt
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_fn(input logic [31:0] a);
      if (a == 32'h0)               return 32'h2008_0005;
      else if (a == 32'h0040_0004)  return 32'h0800_0010;
      else if (a == HALT_PC)        return HALT_WORD;
      else                          return a ^ 32'h2000_0000;
   endfunction

   assign imem_data = imem_fn(pc);

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .imem_data(imem_data), .stall(stall),
      .pc_src(pc_src), .branch_target(branch_target), .pc_jump(pc_jump),
      .jump_sel(jump_sel), .jr_target(jr_target), .pc(pc),
      .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
      .if_id_valid(if_id_valid), .opcode(opcode), .func(func),
      .halted(halted), .fetch_count(fetch_count), .bubble_count(bubble_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pc", pc, m_pc);
      chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("instr", if_id_instr, m_instr);
      chk("pc4", if_id_pc_plus4, m_pc4);
      chk("halted", {31'b0, halted}, {31'b0, m_halted});
      chk("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
      chk("func", {26'b0, func}, {26'b0, m_instr[5:0]});
`ifdef FETCH_STATS_EN
      chk("fetch_count", fetch_count, m_fc);
      chk("bubble_count", bubble_count, m_bc);
`else
      chk("fetch_count", fetch_count, 32'h0);
      chk("bubble_count", bubble_count, 32'h0);
`endif
   endtask

   task automatic model_reset();
      m_state = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_fc = 32'h0; m_bc = 32'h0;
   endtask

   task automatic reset_edge(input logic ps);
      rst_n = 1'b0; stall = 1'b0; pc_src = ps; branch_target = 32'h0000_0300;
      pc_jump = 1'b0; jump_sel = 1'b0; jr_target = 32'h0;
      model_reset();
      sb.delete();
      @(posedge clk); #1;
      check_all();
      rst_n = 1'b1;
   endtask

   task automatic step(input logic s, input logic ps, input logic [31:0] bt,
                       input logic pj, input logic js, input logic [31:0] jt);
      logic [31:0] fetched;
      logic        adv;
      logic [63:0] e;
      stall = s; pc_src = ps; branch_target = bt; pc_jump = pj; jump_sel = js; jr_target = jt;
      fetched = imem_fn(m_pc);
      adv = 1'b0;
      if (m_state == 0) begin
         m_state = 1; m_instr = 32'h0; m_valid = 1'b0; m_bc++;
      end else if (m_state == 1 && !s) begin
         if (m_valid && m_instr == HALT_WORD) begin
            m_state = 2; m_halted = 1'b1;
         end else if (m_valid && (pj || ps)) begin
            if (pj) m_pc = js ? {m_pc4[31:28], m_instr[25:0], 2'b00} : jt;
            else    m_pc = bt;
            m_instr = 32'h0; m_valid = 1'b0; m_bc++;
         end else begin
            sb.push_back({fetched, m_pc + 32'd4});
            m_instr = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_fc++; adv = 1'b1;
         end
      end
      @(posedge clk); #1;
      check_all();
      if (adv) begin
         if (sb.size() == 0) chk("sb_empty", 32'h1, 32'h0);
         else begin
            e = sb.pop_front();
            chk("sb_instr", if_id_instr, e[63:32]);
            chk("sb_pc4", if_id_pc_plus4, e[31:0]);
         end
      end
   endtask

   task automatic run(); step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); endtask

   initial begin
      rst_n = 1'b0;
      reset_edge(1'b0);
      reset_edge(1'b0);
      // boot cycle then first real fetch
      run();
      chk("boot_pc", pc, 32'h0);
      chk("boot_valid", {31'b0, if_id_valid}, 32'h0);
      run();
      chk("first_instr", if_id_instr, 32'h2008_0005);
      chk("first_pc4", if_id_pc_plus4, 32'h4);
      chk("first_opcode", {26'b0, opcode}, 32'h8);
      chk("first_pc", pc, 32'h4);
      run(); run();
      // jr to top of address space, then wrap
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC);
      chk("jr_top_pc", pc, 32'hFFFF_FFFC);
      run();
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_pc4", if_id_pc_plus4, 32'h0);
      // place the j instruction in ID
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0040_0004);
      run();
      chk("j_in_id", if_id_instr, 32'h0800_0010);
      chk("j_pc4", if_id_pc_plus4, 32'h0040_0008);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
      chk("j_pc", pc, 32'h0000_0040);
      chk("j_flush", {31'b0, if_id_valid}, 32'h0);
      run();
      // stall wins over a taken branch
      step(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
      chk("stall_pc", pc, 32'h0000_0044);
      step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
      chk("br_pc", pc, 32'h0000_0100);
      chk("br_flush", if_id_instr, 32'h0);
      // redirect ignored while ID holds a bubble
      step(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0);
      chk("bubble_ignore_pc", pc, 32'h0000_0104);
      // misaligned branch target passes unchanged
      step(1'b0, 1'b1, 32'h0000_01F3, 1'b0, 1'b0, 32'h0);
      chk("misaligned_pc", pc, 32'h0000_01F3);
      run();
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_01FC);
      run(); run();
      chk("halt_in_id", if_id_instr, HALT_WORD);
      run();
      chk("halted", {31'b0, halted}, 32'h1);
      for (int i = 0; i < 10; i++)
         step(1'b0, i[0], 32'h0000_0500, ~i[0], 1'b0, 32'h0000_0800);
      chk("halt_frozen_pc", pc, 32'h0000_0204);
      reset_edge(1'b0);
      chk("halt_reset_halted", {31'b0, halted}, 32'h0);
      run(); run(); run(); run();
      // reset on the same edge as a taken branch
      reset_edge(1'b1);
      chk("midreset_pc", pc, 32'h0);
      run(); run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
